// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC and sequences instr_mem for the fetch stage.
// Handles the boot cycle, stall hold, branch redirect with squash, and range fault.
module fetch_sequencer #(
  parameter logic [31:0] STEP     = 32'd1,
  parameter int unsigned SIZE     = 1024,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] BrDest,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic [31:0] IR,
  output logic        if_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] nPC,
  output logic        fault,
  output logic [1:0]  state,
  output logic [15:0] fetch_cnt,
  output logic [15:0] squash_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [31:0] SIZE_W = 32'(SIZE);

  state_t      st;
  logic [31:0] pc_q;
  logic [31:0] fetch_pc_q;
  logic        if_valid_q;
  logic        fault_q;
  logic [15:0] fetch_cnt_q;
  logic [15:0] squash_cnt_q;
  logic        hold;
  logic        issue;

  // A stall re-reads the displayed PC so the memory output stays put.
  assign hold     = (st == RUN) && stall && !PCSrc;
  assign issue    = !stall || PCSrc;
  assign mem_addr = hold ? fetch_pc_q : pc_q;

  assign IR         = mem_data;
  assign if_valid   = if_valid_q;
  assign fetch_pc   = fetch_pc_q;
  assign nPC        = fetch_pc_q + STEP;
  assign fault      = fault_q;
  assign state      = st;
  assign fetch_cnt  = fetch_cnt_q;
  assign squash_cnt = squash_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= BOOT;
      pc_q         <= RESET_PC;
      fetch_pc_q   <= 32'd0;
      if_valid_q   <= 1'b0;
      fault_q      <= 1'b0;
      fetch_cnt_q  <= 16'd0;
      squash_cnt_q <= 16'd0;
    end else begin
      unique case (st)
        BOOT: begin
          fetch_pc_q <= RESET_PC;
          if_valid_q <= 1'b1;
          pc_q       <= RESET_PC + STEP;
          st         <= RUN;
        end
        RUN: begin
          if (if_valid_q && !stall)
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
          if (issue && (pc_q >= SIZE_W)) begin
            st         <= FAULT;
            fault_q    <= 1'b1;
            if_valid_q <= 1'b0;
          end else if (PCSrc) begin
            pc_q         <= BrDest;
            if_valid_q   <= 1'b0;
            fetch_pc_q   <= pc_q;
            squash_cnt_q <= squash_cnt_q + 16'd1;
          end else if (!stall) begin
            fetch_pc_q <= pc_q;
            if_valid_q <= 1'b1;
            pc_q       <= pc_q + STEP;
          end
        end
        default: begin
          if_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vectors against a synchronous memory model.
// Memory holds mem[i] = 0x100 + i for i < 1024.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        PCSrc;
  logic [31:0] BrDest;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] IR;
  logic        if_valid;
  logic [31:0] fetch_pc;
  logic [31:0] nPC;
  logic        fault;
  logic [1:0]  state;
  logic [15:0] fetch_cnt;
  logic [15:0] squash_cnt;

  int n_vec = 0;
  int n_err = 0;

  fetch_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .PCSrc      (PCSrc),
    .BrDest     (BrDest),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .IR         (IR),
    .if_valid   (if_valid),
    .fetch_pc   (fetch_pc),
    .nPC        (nPC),
    .fault      (fault),
    .state      (state),
    .fetch_cnt  (fetch_cnt),
    .squash_cnt (squash_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    mem_data <= (mem_addr < 32'd1024) ? 32'h100 + mem_addr : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fpc", fetch_pc, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_npc", nPC, 32'd1);
    check("rst_fcnt", 32'(fetch_cnt), 32'd0);
    check("rst_scnt", 32'(squash_cnt), 32'd0);
  endtask

  // Release reset, observe BOOT then four sequential fetches.
  task automatic boot_run();
    reset = 1'b0;
    #1;
    check("boot_state", 32'(state), 32'd0);
    check("boot_valid", 32'(if_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("seq_fpc", fetch_pc, 32'(i));
      check("seq_ir", IR, 32'h100 + 32'(i));
      check("seq_valid", 32'(if_valid), 32'd1);
      check("seq_npc", nPC, 32'(i + 1));
      check("seq_fcnt", 32'(fetch_cnt), 32'(i));
      check("seq_state", 32'(state), 32'd1);
    end
    tick();
    check("seq_fpc4", fetch_pc, 32'd4);
    check("seq_fcnt4", 32'(fetch_cnt), 32'd4);
    check("seq_scnt", 32'(squash_cnt), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    stall  = 1'b0;
    PCSrc  = 1'b0;
    BrDest = 32'd0;
    tick();
    tick();
    chk_reset_vals();

    boot_run();

    // Stall for three cycles with 0x102 on IR.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("pre_stall_ir", IR, 32'h102);
    check("pre_stall_fcnt", 32'(fetch_cnt), 32'd2);
    stall = 1'b1;
    #1;
    check("stall_addr0", mem_addr, 32'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_ir", IR, 32'h102);
      check("stall_fpc", fetch_pc, 32'd2);
      check("stall_valid", 32'(if_valid), 32'd1);
      check("stall_fcnt", 32'(fetch_cnt), 32'd2);
      check("stall_addr", mem_addr, 32'd2);
      if (k == 2) stall = 1'b0;
    end
    tick();
    check("unstall_ir", IR, 32'h103);
    check("unstall_fpc", fetch_pc, 32'd3);
    check("unstall_fcnt", 32'(fetch_cnt), 32'd3);

    // Plain redirect from fetch_pc 5 to 0x40.
    tick();
    tick();
    check("br_pre_fpc", fetch_pc, 32'd5);
    PCSrc  = 1'b1;
    BrDest = 32'h40;
    tick();
    PCSrc = 1'b0;
    check("br_bubble", 32'(if_valid), 32'd0);
    check("br_scnt", 32'(squash_cnt), 32'd1);
    check("br_fcnt", 32'(fetch_cnt), 32'd6);
    tick();
    check("br_ir", IR, 32'h140);
    check("br_fpc", fetch_pc, 32'h40);
    check("br_valid", 32'(if_valid), 32'd1);
    check("br_fcnt2", 32'(fetch_cnt), 32'd6);

    // Redirect and stall together behave as a redirect.
    PCSrc  = 1'b1;
    stall  = 1'b1;
    BrDest = 32'h10;
    #1;
    check("brst_addr", mem_addr, 32'h41);
    tick();
    PCSrc = 1'b0;
    stall = 1'b0;
    check("brst_bubble", 32'(if_valid), 32'd0);
    check("brst_scnt", 32'(squash_cnt), 32'd2);
    check("brst_fcnt", 32'(fetch_cnt), 32'd6);
    tick();
    check("brst_ir", IR, 32'h110);
    check("brst_fpc", fetch_pc, 32'h10);
    check("brst_valid", 32'(if_valid), 32'd1);

    // Branch to the last legal word, then run off the end.
    PCSrc  = 1'b1;
    BrDest = 32'd1023;
    tick();
    PCSrc = 1'b0;
    check("end_bubble", 32'(if_valid), 32'd0);
    tick();
    check("end_ir", IR, 32'h4FF);
    check("end_valid", 32'(if_valid), 32'd1);
    check("end_fault0", 32'(fault), 32'd0);
    tick();
    check("flt_fault", 32'(fault), 32'd1);
    check("flt_state", 32'(state), 32'd2);
    check("flt_valid", 32'(if_valid), 32'd0);
    PCSrc  = 1'b1;
    BrDest = 32'd5;
    for (int k = 0; k < 10; k++) begin
      stall = k[0];
      tick();
      check("frz_fault", 32'(fault), 32'd1);
      check("frz_state", 32'(state), 32'd2);
      check("frz_valid", 32'(if_valid), 32'd0);
      check("frz_fpc", fetch_pc, 32'd1023);
      check("frz_npc", nPC, 32'd1024);
      check("frz_addr", mem_addr, 32'd1024);
      check("frz_fcnt", 32'(fetch_cnt), 32'd8);
      check("frz_scnt", 32'(squash_cnt), 32'd3);
    end
    PCSrc = 1'b0;
    stall = 1'b0;

    // Recover, run to fetch_pc 7, then reset asynchronously.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("pre_rst_fpc", fetch_pc, 32'd7);
    check("pre_rst_fcnt", 32'(fetch_cnt), 32'd7);
    reset = 1'b1;
    #1;
    chk_reset_vals();
    boot_run();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller that owns the program counter and sequences the synchronous instruction memory for the fetch stage. It issues fetch addresses, holds the delivered instruction under stall, redirects on taken branches with a one-slot squash, and faults on out-of-range fetches. It sits between the hazard/branch logic (stall, PCSrc, BrDest) and `instr_mem`. It presents a valid-qualified instruction and its PC to decode.

## Interface
- STEP, 32'd1, PC increment per sequential fetch (word-addressed memory)
- SIZE, 1024, instruction memory depth in words; legal PCs are 0..SIZE-1
- RESET_PC, 32'd0, first fetch address after reset

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- stall  input  1  decode cannot accept; hold the delivered instruction
- PCSrc  input  1  taken branch/jump this cycle
- BrDest  input  `WORD  redirect target, sampled when PCSrc=1
- mem_addr  output  `WORD  address to `instr_mem` .pc (combinational)
- mem_data  input  `WORD  `instr_mem` .instruction, registered inside memory
- IR  output  `WORD  instruction to decode (= mem_data)
- if_valid  output  1  IR/fetch_pc hold a real instruction
- fetch_pc  output  `WORD  PC of instruction on IR
- nPC  output  `WORD  fetch_pc + STEP
- fault  output  1  sticky out-of-range fetch flag
- state  output  2  BOOT=0, RUN=1, FAULT=2
- fetch_cnt  output  16  instructions accepted by decode, wraps
- squash_cnt  output  16  redirects taken, wraps

## Operation
- Registers: pc_q (next address to issue), fetch_pc_q, if_valid_q, state, fault, both counters.
- Reset values: pc_q=RESET_PC, fetch_pc=0, if_valid=0, fault=0, state=BOOT, counters=0. Combinationally, mem_addr=RESET_PC and nPC=STEP.
- mem_addr = fetch_pc_q when (state==RUN && stall && !PCSrc); otherwise pc_q. While stalled, the memory re-reads the displayed instruction, so IR is held stable.
- BOOT (exactly one cycle): stall and PCSrc are ignored.
  - Next edge: fetch_pc<=RESET_PC, if_valid<=1, pc_q<=RESET_PC+STEP, state<=RUN.
- RUN, priority is fault check > PCSrc > stall > advance.
  - Fault check (unstalled issue only): if pc_q >= SIZE, then state<=FAULT, fault<=1, if_valid<=0, pc_q frozen.
  - PCSrc=1: pc_q<=BrDest, if_valid<=0 (squash), fetch_pc<=pc_q, squash_cnt++. A branch during stall overrides the stall.
  - stall=1: pc_q, fetch_pc and if_valid are unchanged.
  - Advance: fetch_pc<=pc_q, if_valid<=1, pc_q<=pc_q+STEP.
- fetch_cnt++ on every edge where if_valid=1 && stall=0 && state==RUN.
- A BrDest >= SIZE is accepted. It faults on the following issue cycle, with no instruction delivered.
- FAULT: all registers are frozen and if_valid=0. Only reset exits this state.
- Arithmetic: all PC adds are `WORD-bit modulo 2^32. Counters wrap 0xFFFF->0.

## Timing
- Fetch latency: an address issued in cycle n gives IR, fetch_pc and if_valid=1 in cycle n+1.
- Sequential throughput: one instruction per cycle.
- Branch penalty: with PCSrc in cycle n, cycle n+1 is a bubble (if_valid=0) and mem[BrDest] is valid in cycle n+2.
- Stall asserted in cycles n..m: outputs in n+1..m+1 equal those of cycle n. The next instruction appears in cycle m+2.
- A PCSrc and stall in the same cycle behave as PCSrc alone.
- Reset asserted mid-operation clears everything asynchronously. After release, the BOOT cycle then RUN; the first valid instruction appears one cycle after BOOT.

## Test plan
Memory preload: STEP=1, SIZE=1024, RESET_PC=0, mem[i]=0x100+i.
- Reset release, no stall/branch for 5 cycles: cycle 1 BOOT with if_valid=0. fetch_pc 0,1,2,3 with IR 0x100..0x103 and if_valid=1, nPC=fetch_pc+1, fetch_cnt=4.
- Stall for 3 cycles while IR=0x102: IR=0x102, fetch_pc=2 and if_valid=1 are held for 3 cycles, with mem_addr=2. Next cycle IR=0x103. fetch_cnt does not increment during the stall.
- PCSrc=1 with BrDest=0x40 while fetch_pc=5: next cycle if_valid=0, then IR=0x140 with fetch_pc=0x40. squash_cnt=1.
- PCSrc with BrDest=0x10 and stall in the same cycle: same response as a plain redirect, with IR=0x110 two cycles later.
- BrDest=1023 then free-run: IR=0x4FF valid, the next cycle gives fault=1, state=2 and if_valid=0. All outputs stay frozen for 10 cycles.
- Reset pulse mid-stream at fetch_pc=7: outputs go to reset values immediately, without waiting for a clock edge. The bench then repeats scenario 1 exactly, with counters back at 0.
